dpram_36k_port_arbiter: RTL and testbench
=========================================

# dpram_36k_port_arbiter

Two-requester round-robin arbiter that time-shares one port of a DPRAM_36K_BLK instance (one write channel plus one read channel driven from the same clock). It accepts single-word read/write commands from requesters 0 and 1 and grants at most one command per cycle. It registers the command onto the RAM port and routes registered read data back to the requester that issued the read. It sits between client logic and the `*_1` port of the block RAM wrapper; the RAM's second port is untouched.

## Interface
- ADDR_WIDTH, 10, RAM word address width (10/11/12 for x36/x18/x9 modes).
- DATA_WIDTH, 36, RAM word width (36/18/9).
- RD_LATENCY, 1, RAM read latency in cycles from REN/RD_ADDR edge to valid RAM_RDATA_i; legal values 1, 2.
- CLK_i  input  1  single clock for arbiter and RAM port; all logic rising-edge.
- RST_i  input  1  asynchronous, active-high reset.
- REQ0_i / REQ1_i  input  1  command request; held with payload stable until granted.
- WE0_i / WE1_i  input  1  1 = write, 0 = read.
- ADDR0_i / ADDR1_i  input  ADDR_WIDTH  word address.
- WDATA0_i / WDATA1_i  input  DATA_WIDTH  write data (ignored for reads).
- GNT0_o / GNT1_o  output  1  combinational; command accepted this cycle.
- RVALID0_o / RVALID1_o  output  1  one-cycle pulse, read data valid.
- RDATA0_o / RDATA1_o  output  DATA_WIDTH  registered read data; holds its value between pulses.
- RAM_WEN_o  output  1  to WEN1_i.
- RAM_REN_o  output  1  to REN1_i.
- RAM_WR_ADDR_o / RAM_RD_ADDR_o  output  ADDR_WIDTH  to WR1_ADDR_i / RD1_ADDR_i.
- RAM_WDATA_o  output  DATA_WIDTH  to WDATA1_i; byte enables are tied all-ones outside this block.
- RAM_RDATA_i  input  DATA_WIDTH  from RDATA1_o.

## Operation
- Priority state `prio` (1 bit) names the favoured requester. Reset value is 0.
- Grant rule for each cycle:
  - Only REQ0 high: GNT0.
  - Only REQ1 high: GNT1.
  - Both high: grant `prio`.
  - Neither high: no grant.
- At most one GNT is high per cycle.
- On any grant to n, `prio` becomes 1-n at the next edge. With no grant, `prio` holds.
- Sustained dual requests therefore alternate 0,1,0,1…
- Granted write: RAM_WEN_o=1, RAM_WR_ADDR_o=ADDR, RAM_WDATA_o=WDATA, all registered (next cycle); RAM_REN_o=0.
- Granted read: RAM_REN_o=1 and RAM_RD_ADDR_o=ADDR, registered; RAM_WEN_o=0.
- No grant: RAM_WEN_o=RAM_REN_o=0. Address and data outputs hold their last values.
- Read return tracking:
  - A shift register of RD_LATENCY+1 stages carries {valid, requester id} per issued read.
  - When the final stage is valid, RAM_RDATA_i is captured into RDATAn_o of the tagged requester, and RVALIDn_o pulses for one cycle.
  - The other requester's RDATA and RVALID are unaffected.
- No backpressure on read return; requesters must accept RVALID pulses.
- Write-then-read ordering: a read granted in any cycle after a write to the same address returns the new data. Commands reach the RAM in grant order and one per cycle, so no hazard logic is required.
- Reset (asynchronous, any time), all take effect immediately:
  - `prio`=0.
  - RAM_WEN_o=RAM_REN_o=0.
  - RAM addresses, RAM_WDATA_o and RDATAn_o cleared to 0.
  - RVALIDn_o=0.
  - Tag pipeline cleared: in-flight reads are discarded and never produce RVALID.
- GNT outputs are gated low while RST_i is high.

## Timing
- Grant cycle: T.
- RAM command on port: T+1.
- RAM_RDATA_i valid: T+1+RD_LATENCY.
- RVALIDn_o/RDATAn_o: T+2+RD_LATENCY, i.e. 3 cycles after grant for RD_LATENCY=1, 4 for RD_LATENCY=2.
- Throughput is one command per cycle total, sustained. Back-to-back reads from either requester produce back-to-back RVALID pulses in grant order.
- Write completion is invisible to the requester: the grant cycle is the only acknowledgement.
- GNT depends combinationally on REQ0_i/REQ1_i and `prio` only, not on WE, ADDR or WDATA.

## Test plan
- Reset, then idle:
  - All outputs 0; no RAM strobes.
  - Assert RST_i mid-read; no RVALID appears afterwards.
- Requester 0 writes 0x123456789 to addr 5 at T0, then reads addr 5 at T1 (RD_LATENCY=1):
  - GNT0 at T0 and T1.
  - RAM_WEN_o at T0+1, RAM_REN_o at T1+1.
  - RVALID0_o with RDATA0_o=0x123456789 at T1+3.
- Both requesters hold read requests for 6 cycles:
  - Grants go 0,1,0,1,0,1.
  - RVALID0/RVALID1 alternate starting 3 cycles after first grant, each returning its own address's data.
- Requester 1 alone for 3 cycles, then both request:
  - After grants to 1 at cycles 0-2, `prio`=0, so requester 0 wins cycle 3 and requester 1 wins cycle 4.
- RD_LATENCY=2, DATA_WIDTH=9, ADDR_WIDTH=12:
  - Write 0x1A5 to addr 4095 via requester 1, then read it via requester 0.
  - RVALID0_o with RDATA0_o=0x1A5 exactly 4 cycles after the read grant.
  - RDATA1_o unchanged.

Source files
------------

// File: rtl/dpram_36k_port_arbiter_if.sv
// rtl/dpram_36k_port_arbiter_if.sv - requester and RAM-port signal bundle for the DPRAM port arbiter
//
// Groups both sides of the arbiter:
//   requester side : req0/req1, we0/we1, addr0/addr1, wdata0/wdata1 (in to arbiter)
//                    gnt0/gnt1, rvalid0/rvalid1, rdata0/rdata1 (out of arbiter)
//   RAM port side  : ram_wen, ram_ren, ram_wr_addr, ram_rd_addr, ram_wdata (out of arbiter)
//                    ram_rdata (in to arbiter, from the block RAM read port)
// slave  modport : the arbiter.
// master modport : the clients plus the block RAM that surround it.
interface dpram_36k_port_arbiter_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 36
);
  logic                  req0;
  logic                  req1;
  logic                  we0;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata0;
  logic [DATA_WIDTH-1:0] wdata1;

  logic                  gnt0;
  logic                  gnt1;
  logic                  rvalid0;
  logic                  rvalid1;
  logic [DATA_WIDTH-1:0] rdata0;
  logic [DATA_WIDTH-1:0] rdata1;

  logic                  ram_wen;
  logic                  ram_ren;
  logic [ADDR_WIDTH-1:0] ram_wr_addr;
  logic [ADDR_WIDTH-1:0] ram_rd_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           ram_wen, ram_ren, ram_wr_addr, ram_rd_addr, ram_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           ram_wen, ram_ren, ram_wr_addr, ram_rd_addr, ram_wdata
  );
endinterface

// File: rtl/dpram_36k_port_arbiter.sv
// rtl/dpram_36k_port_arbiter.sv - two-requester round-robin arbiter for one block RAM port
//
// Time-shares the write+read channel pair of one block RAM port between two
// requesters, one single-word command per cycle.
//   clk : single rising-edge clock for arbiter and RAM port
//   rst : asynchronous, active-high reset
//   bus : dpram_36k_port_arbiter_if.slave
//         gnt0/gnt1     combinational accept, gated low during reset
//         ram_*         registered command onto the RAM port (one cycle after grant)
//         rvalid/rdata  registered read return, RD_LATENCY+2 cycles after grant
module dpram_36k_port_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 36,
  parameter int RD_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  dpram_36k_port_arbiter_if.slave  bus
);

  // One tag stage per cycle between grant and the cycle RAM read data is valid.
  localparam int STAGES = RD_LATENCY + 1;
  localparam int LAST   = STAGES - 1;

  typedef enum logic {
    PRIO_0 = 1'b0,
    PRIO_1 = 1'b1
  } prio_e;

  prio_e                 prio_q;
  prio_e                 prio_d;
  logic                  gnt0;
  logic                  gnt1;
  logic                  grant;

  logic                  cmd_we;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;

  logic                  ram_wen_q;
  logic                  ram_ren_q;
  logic [ADDR_WIDTH-1:0] ram_wr_addr_q;
  logic [ADDR_WIDTH-1:0] ram_rd_addr_q;
  logic [DATA_WIDTH-1:0] ram_wdata_q;

  logic [STAGES-1:0]     tag_vld;
  logic [STAGES-1:0]     tag_id;

  logic                  rvalid0_q;
  logic                  rvalid1_q;
  logic [DATA_WIDTH-1:0] rdata0_q;
  logic [DATA_WIDTH-1:0] rdata1_q;

  logic                  ret0;
  logic                  ret1;

  // Priority register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q <= PRIO_0;
    end else begin
      prio_q <= prio_d;
    end
  end

  // Grant decision and next priority. Only req/prio feed the grant so that
  // client payload timing never reaches the grant path.
  always_comb begin
    prio_d = prio_q;
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    if (!rst) begin
      if (bus.req0 && (!bus.req1 || prio_q == PRIO_0)) begin
        gnt0 = 1'b1;
      end else if (bus.req1) begin
        gnt1 = 1'b1;
      end
    end
    if (gnt0) begin
      prio_d = PRIO_1;
    end else if (gnt1) begin
      prio_d = PRIO_0;
    end
  end

  assign grant = gnt0 | gnt1;

  // Granted command selection; with no grant the mux value is don't-care.
  always_comb begin
    cmd_we    = bus.we0;
    cmd_addr  = bus.addr0;
    cmd_wdata = bus.wdata0;
    if (gnt1) begin
      cmd_we    = bus.we1;
      cmd_addr  = bus.addr1;
      cmd_wdata = bus.wdata1;
    end
  end

  // RAM port command register. Address/data only load on their own strobe
  // so the port holds steady while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_wen_q     <= 1'b0;
      ram_ren_q     <= 1'b0;
      ram_wr_addr_q <= '0;
      ram_rd_addr_q <= '0;
      ram_wdata_q   <= '0;
    end else begin
      ram_wen_q <= grant && cmd_we;
      ram_ren_q <= grant && !cmd_we;
      if (grant && cmd_we) begin
        ram_wr_addr_q <= cmd_addr;
        ram_wdata_q   <= cmd_wdata;
      end
      if (grant && !cmd_we) begin
        ram_rd_addr_q <= cmd_addr;
      end
    end
  end

  // Read tag pipeline: stage 0 lines up with the RAM command, the last stage
  // lines up with valid RAM read data. Reset drops in-flight reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld <= '0;
      tag_id  <= '0;
    end else begin
      tag_vld <= {tag_vld[STAGES-2:0], grant && !cmd_we};
      tag_id  <= {tag_id[STAGES-2:0], gnt1};
    end
  end

  assign ret0 = tag_vld[LAST] && !tag_id[LAST];
  assign ret1 = tag_vld[LAST] &&  tag_id[LAST];

  // Read return: steer RAM data to the tagged requester only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= ret0;
      rvalid1_q <= ret1;
      if (ret0) begin
        rdata0_q <= bus.ram_rdata;
      end
      if (ret1) begin
        rdata1_q <= bus.ram_rdata;
      end
    end
  end

  assign bus.gnt0        = gnt0;
  assign bus.gnt1        = gnt1;
  assign bus.ram_wen     = ram_wen_q;
  assign bus.ram_ren     = ram_ren_q;
  assign bus.ram_wr_addr = ram_wr_addr_q;
  assign bus.ram_rd_addr = ram_rd_addr_q;
  assign bus.ram_wdata   = ram_wdata_q;
  assign bus.rvalid0     = rvalid0_q;
  assign bus.rvalid1     = rvalid1_q;
  assign bus.rdata0      = rdata0_q;
  assign bus.rdata1      = rdata1_q;

endmodule

// File: tb/tb_dpram_36k_port_arbiter.sv
// tb/tb_dpram_36k_port_arbiter.sv - randomized model-checked bench for dpram_36k_port_arbiter
module tb_dpram_36k_port_arbiter;

  localparam int AW  = 10;
  localparam int DW  = 36;
  localparam int L   = 1;
  localparam int AW2 = 12;
  localparam int DW2 = 9;
  localparam int L2  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  dpram_36k_port_arbiter_if #(.ADDR_WIDTH(AW),  .DATA_WIDTH(DW))  bus_a ();
  dpram_36k_port_arbiter_if #(.ADDR_WIDTH(AW2), .DATA_WIDTH(DW2)) bus_b ();

  dpram_36k_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(L)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  dpram_36k_port_arbiter #(.ADDR_WIDTH(AW2), .DATA_WIDTH(DW2), .RD_LATENCY(L2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  // Block RAM stand-ins with the configured read latency.
  logic [DW-1:0]  mem_a   [0:(1<<AW)-1];
  logic [DW-1:0]  rpipe_a [0:L-1];
  logic [DW2-1:0] mem_b   [0:(1<<AW2)-1];
  logic [DW2-1:0] rpipe_b [0:L2-1];

  always @(posedge clk) begin
    if (bus_a.ram_wen) mem_a[bus_a.ram_wr_addr] <= bus_a.ram_wdata;
    if (bus_a.ram_ren) rpipe_a[0] <= mem_a[bus_a.ram_rd_addr];
    for (int i = 1; i < L; i++) rpipe_a[i] <= rpipe_a[i-1];
    if (bus_b.ram_wen) mem_b[bus_b.ram_wr_addr] <= bus_b.ram_wdata;
    if (bus_b.ram_ren) rpipe_b[0] <= mem_b[bus_b.ram_rd_addr];
    for (int i = 1; i < L2; i++) rpipe_b[i] <= rpipe_b[i-1];
  end
  assign bus_a.ram_rdata = rpipe_a[L-1];
  assign bus_b.ram_rdata = rpipe_b[L2-1];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Reference model state for instance A.
  typedef struct {
    int          id;
    logic [DW-1:0] data;
    int          due;
  } rd_t;

  rd_t           rq[$];
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  logic [DW-1:0] held [2];
  int            prio_m;
  int            cyc;
  logic          exp_wen, exp_ren;
  logic [AW-1:0] exp_wa, exp_ra;
  logic [DW-1:0] exp_wd;

  // Pending commands per requester.
  logic          p_req [2];
  logic          p_we  [2];
  logic [AW-1:0] p_addr[2];
  logic [DW-1:0] p_wd  [2];

  task automatic issue(input int n, input logic we, input int addr, input logic [DW-1:0] wd);
    p_req[n]  = 1'b1;
    p_we[n]   = we;
    p_addr[n] = addr[AW-1:0];
    p_wd[n]   = wd;
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  task automatic model_reset();
    rq.delete();
    prio_m  = 0;
    exp_wen = 1'b0;
    exp_ren = 1'b0;
    held[0] = '0;
    held[1] = '0;
    p_req[0] = 1'b0;
    p_req[1] = 1'b0;
  endtask

  // One cycle on instance A: entered at posedge+1, leaves at next posedge+1.
  task automatic tick();
    int  win;
    logic ev0, ev1;
    bus_a.req0 = p_req[0]; bus_a.we0 = p_we[0]; bus_a.addr0 = p_addr[0]; bus_a.wdata0 = p_wd[0];
    bus_a.req1 = p_req[1]; bus_a.we1 = p_we[1]; bus_a.addr1 = p_addr[1]; bus_a.wdata1 = p_wd[1];
    @(negedge clk);
    // Round-robin rule: a lone requester wins, a tie goes to the favoured one.
    if (p_req[0] && p_req[1]) win = prio_m;
    else if (p_req[0])        win = 0;
    else if (p_req[1])        win = 1;
    else                      win = -1;
    chk("gnt0", bus_a.gnt0, win == 0);
    chk("gnt1", bus_a.gnt1, win == 1);
    chk("ram_wen", bus_a.ram_wen, exp_wen);
    chk("ram_ren", bus_a.ram_ren, exp_ren);
    if (exp_wen) begin
      chk("ram_wr_addr", bus_a.ram_wr_addr, exp_wa);
      chk("ram_wdata", bus_a.ram_wdata, exp_wd);
    end
    if (exp_ren) chk("ram_rd_addr", bus_a.ram_rd_addr, exp_ra);
    ev0 = 1'b0;
    ev1 = 1'b0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      if (rq[0].id == 0) ev0 = 1'b1; else ev1 = 1'b1;
      held[rq[0].id] = rq[0].data;
      void'(rq.pop_front());
    end
    chk("rvalid0", bus_a.rvalid0, ev0);
    chk("rvalid1", bus_a.rvalid1, ev1);
    chk("rdata0", bus_a.rdata0, held[0]);
    chk("rdata1", bus_a.rdata1, held[1]);
    exp_wen = 1'b0;
    exp_ren = 1'b0;
    if (win >= 0) begin
      prio_m = 1 - win;
      if (p_we[win]) begin
        shadow[p_addr[win]] = p_wd[win];
        exp_wen = 1'b1;
        exp_wa  = p_addr[win];
        exp_wd  = p_wd[win];
      end else begin
        exp_ren = 1'b1;
        exp_ra  = p_addr[win];
        rq.push_back('{id: win, data: shadow[p_addr[win]], due: cyc + 2 + L});
      end
      p_req[win] = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Asynchronous reset applied mid-cycle; outputs must clear without a clock edge.
  task automatic apply_reset();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_ram_wen", bus_a.ram_wen, 1'b0);
    chk("rst_ram_ren", bus_a.ram_ren, 1'b0);
    chk("rst_rvalid0", bus_a.rvalid0, 1'b0);
    chk("rst_rvalid1", bus_a.rvalid1, 1'b0);
    chk("rst_wr_addr", bus_a.ram_wr_addr, 0);
    chk("rst_rd_addr", bus_a.ram_rd_addr, 0);
    chk("rst_wdata", bus_a.ram_wdata, 0);
    chk("rst_rdata0", bus_a.rdata0, 0);
    chk("rst_rdata1", bus_a.rdata1, 0);
    chk("rst_b_rdata1", bus_b.rdata1, 0);
    bus_a.req0 = 1'b1;
    bus_a.req1 = 1'b1;
    #1;
    chk("rst_gnt0_gated", bus_a.gnt0, 1'b0);
    chk("rst_gnt1_gated", bus_a.gnt1, 1'b0);
    bus_a.req0 = 1'b0;
    bus_a.req1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    bus_a.req0 = 0; bus_a.req1 = 0; bus_a.we0 = 0; bus_a.we1 = 0;
    bus_a.addr0 = '0; bus_a.addr1 = '0; bus_a.wdata0 = '0; bus_a.wdata1 = '0;
    bus_b.req0 = 0; bus_b.req1 = 0; bus_b.we0 = 0; bus_b.we1 = 0;
    bus_b.addr0 = '0; bus_b.addr1 = '0; bus_b.wdata0 = '0; bus_b.wdata1 = '0;
    cyc = 0;
    p_we[0] = 0; p_we[1] = 0; p_addr[0] = '0; p_addr[1] = '0; p_wd[0] = '0; p_wd[1] = '0;
    model_reset();
    @(posedge clk);
    #1;
    apply_reset();
    repeat (3) tick();

    // Write then read the same address from requester 0.
    issue(0, 1'b1, 5, 36'h123456789);
    tick();
    issue(0, 1'b0, 5, '0);
    tick();
    repeat (4) tick();

    // Preload a small address window so every later read has a known value.
    for (int a = 0; a < 8; a++) begin
      issue(0, 1'b1, a, rnd_data());
      tick();
    end
    repeat (3) tick();

    // Reset while a read is in flight: its return must never appear.
    issue(0, 1'b0, 1, '0);
    tick();
    tick();
    apply_reset();
    repeat (6) tick();

    // Both requesters reading continuously for six cycles.
    for (int i = 0; i < 6; i++) begin
      if (!p_req[0]) issue(0, 1'b0, 2, '0);
      if (!p_req[1]) issue(1, 1'b0, 3, '0);
      tick();
    end
    repeat (6) tick();

    // Requester 1 alone for three cycles, then both contend.
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      issue(1, 1'b0, 4, '0);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      if (!p_req[0]) issue(0, 1'b0, 6, '0);
      if (!p_req[1]) issue(1, 1'b0, 7, '0);
      tick();
    end
    repeat (6) tick();

    // Randomized mix of reads and writes from both requesters.
    for (int i = 0; i < 400; i++) begin
      for (int n = 0; n < 2; n++) begin
        if (!p_req[n] && $urandom_range(0, 3) != 0)
          issue(n, 1'($urandom_range(0, 1)), $urandom_range(0, 7), rnd_data());
      end
      tick();
    end
    repeat (8) tick();
    chk("reads_drained", rq.size(), 0);

    // Narrow/deep configuration with two-cycle RAM read latency.
    bus_b.req1 = 1'b1; bus_b.we1 = 1'b1; bus_b.addr1 = 12'hFFF; bus_b.wdata1 = 9'h1A5;
    @(negedge clk);
    chk("b_gnt1_write", bus_b.gnt1, 1'b1);
    chk("b_gnt0_idle", bus_b.gnt0, 1'b0);
    @(posedge clk);
    #1;
    bus_b.req1 = 1'b0;
    bus_b.req0 = 1'b1; bus_b.we0 = 1'b0; bus_b.addr0 = 12'hFFF;
    @(negedge clk);
    chk("b_ram_wen", bus_b.ram_wen, 1'b1);
    chk("b_wr_addr", bus_b.ram_wr_addr, 12'hFFF);
    chk("b_wdata", bus_b.ram_wdata, 9'h1A5);
    chk("b_gnt0_read", bus_b.gnt0, 1'b1);
    @(posedge clk);
    #1;
    bus_b.req0 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("b_ram_ren", bus_b.ram_ren, 1'b1);
        chk("b_rd_addr", bus_b.ram_rd_addr, 12'hFFF);
      end
      chk($sformatf("b_rvalid0_k%0d", k), bus_b.rvalid0, k == 4);
      chk($sformatf("b_rvalid1_k%0d", k), bus_b.rvalid1, 1'b0);
      chk($sformatf("b_rdata1_k%0d", k), bus_b.rdata1, 0);
      if (k >= 4) chk($sformatf("b_rdata0_k%0d", k), bus_b.rdata0, 9'h1A5);
      @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
